// File: rtl/piso_serializer.sv
`default_nettype none
// ============================================================================
//  Module   : piso_serializer
//  Function : Parallel-in serial-out transmitter. Accepts a word over a
//             valid/ready handshake and shifts it out MSB first, one bit per
//             shift_en tick, with gap-free back-to-back frames.
//  Revision : 1.0  initial release
// ============================================================================
module piso_serializer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             clear_n,
    input  logic [WIDTH-1:0] din,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic             shift_en,
    output logic             so,
    output logic             so_valid,
    output logic             last
);

    localparam int                C_CNT_W  = $clog2(WIDTH);
    localparam logic [C_CNT_W-1:0] C_LAST   = C_CNT_W'(WIDTH - 1);
    localparam logic [C_CNT_W-1:0] C_PENULT = C_CNT_W'(WIDTH - 2);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t             state_q;
    logic [WIDTH-1:0]   sreg_q;
    logic [C_CNT_W-1:0] cnt_q;
    logic               last_q;

    logic               w_final_tick;
    logic               w_accept;

    // Final bit is being consumed this edge: the only SHIFT cycle that can take a new word.
    assign w_final_tick = (state_q == SHIFT) && (cnt_q == C_LAST) && shift_en;
    assign load_ready   = (state_q == IDLE) || w_final_tick;
    assign w_accept     = load_valid && load_ready;

    // Frame sequencing: load, shift, back-to-back reload or return to idle.
    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            state_q <= IDLE;
            sreg_q  <= '0;
            cnt_q   <= '0;
            last_q  <= 1'b0;
        end else if (w_accept) begin
            // New word: MSB appears on so straight after this edge.
            state_q <= SHIFT;
            sreg_q  <= din;
            cnt_q   <= '0;
            last_q  <= 1'b0;
        end else if (state_q == SHIFT && shift_en) begin
            if (cnt_q == C_LAST) begin
                // Frame done and nothing waiting: clear so the line idles low.
                state_q <= IDLE;
                sreg_q  <= '0;
                cnt_q   <= '0;
                last_q  <= 1'b0;
            end else begin
                sreg_q  <= {sreg_q[WIDTH-2:0], 1'b0};
                cnt_q   <= cnt_q + 1'b1;
                last_q  <= (cnt_q == C_PENULT);
            end
        end
    end

    // Outputs come straight from flops; sreg is zero in IDLE so so idles low.
    assign so       = sreg_q[WIDTH-1];
    assign so_valid = (state_q == SHIFT);
    assign last     = last_q;

endmodule
`default_nettype wire

// File: tb/tb_piso_serializer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_piso_serializer
//  Function : Self-checking bench for piso_serializer (WIDTH = 8). A queue
//             of pending frame bits models the transmitter; directed
//             scenarios pin literal values, then random traffic runs.
//  Revision : 1.0  initial release
// ============================================================================
module tb_piso_serializer;

    localparam int WIDTH = 8;

    logic             clk        = 1'b0;
    logic             clear_n    = 1'b0;
    logic [WIDTH-1:0] din        = '0;
    logic             load_valid = 1'b0;
    logic             shift_en   = 1'b0;
    logic             load_ready;
    logic             so;
    logic             so_valid;
    logic             last;

    int n_checks = 0;
    int n_fails  = 0;

    piso_serializer #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .clear_n    (clear_n),
        .din        (din),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .shift_en   (shift_en),
        .so         (so),
        .so_valid   (so_valid),
        .last       (last)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the bits of the current frame still to be sent, MSB first.
    bit mq[$];

    always @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            mq.delete();
        end else begin
            bit rdy;
            rdy = (mq.size() == 0) || (mq.size() == 1 && shift_en);
            if (load_valid && rdy) begin
                mq.delete();
                for (int i = WIDTH - 1; i >= 0; i--) mq.push_back(din[i]);
            end else if (shift_en && mq.size() > 0) begin
                void'(mq.pop_front());
            end
        end
    end

    // Every-cycle comparison against the model, mid-cycle.
    always @(negedge clk) begin
        logic e_so, e_v, e_last, e_rdy;
        e_v    = (mq.size() > 0);
        e_so   = e_v ? mq[0] : 1'b0;
        e_last = (mq.size() == 1);
        e_rdy  = (mq.size() == 0) || (mq.size() == 1 && shift_en);
        check("model_so",         {7'd0, so},         {7'd0, e_so});
        check("model_so_valid",   {7'd0, so_valid},   {7'd0, e_v});
        check("model_last",       {7'd0, last},       {7'd0, e_last});
        check("model_load_ready", {7'd0, load_ready}, {7'd0, e_rdy});
    end

    // Receive-side SIPO for loopback.
    logic       sipo_clr = 1'b0;
    logic [7:0] po;
    always @(posedge clk) begin
        if (sipo_clr)      po <= 8'h00;
        else if (shift_en) po <= {po[6:0], so};
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] pat;

        // ---------------- reset values, load held during reset ----------------
        load_valid = 1'b1;
        din        = 8'hFF;
        repeat (3) begin
            tick();
            check("rst_so",       {7'd0, so},       8'd0);
            check("rst_so_valid", {7'd0, so_valid}, 8'd0);
            check("rst_last",     {7'd0, last},     8'd0);
        end
        #2 clear_n = 1'b1;
        tick();
        check("first_edge_accept_valid", {7'd0, so_valid}, 8'd1);
        check("first_edge_accept_so",    {7'd0, so},       8'd1);
        load_valid = 1'b0;
        shift_en   = 1'b1;
        repeat (8) tick();
        shift_en = 1'b0;
        check("drain_idle", {7'd0, so_valid}, 8'd0);
        tick();

        // ---------------- single frame A5 ----------------
        pat        = 8'hA5;
        din        = pat;
        load_valid = 1'b1;
        shift_en   = 1'b1;
        tick();
        load_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            check("a5_so",    {7'd0, so},       {7'd0, pat[7-i]});
            check("a5_valid", {7'd0, so_valid}, 8'd1);
            check("a5_last",  {7'd0, last},     {7'd0, (i == 7)});
            tick();
        end
        check("a5_end_valid", {7'd0, so_valid}, 8'd0);
        shift_en = 1'b0;
        tick();

        // ---------------- loopback 3C then C3 back-to-back ----------------
        sipo_clr   = 1'b1;
        din        = 8'h3C;
        load_valid = 1'b1;
        shift_en   = 1'b1;
        tick();
        sipo_clr = 1'b0;
        din      = 8'hC3;
        for (int i = 0; i < 8; i++) begin
            check("loop_valid1", {7'd0, so_valid}, 8'd1);
            tick();
        end
        check("loop_po_3c", po, 8'h3C);
        load_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            check("loop_valid2", {7'd0, so_valid}, 8'd1);
            tick();
        end
        check("loop_po_c3",    po,                8'hC3);
        check("loop_end_idle", {7'd0, so_valid},  8'd0);
        shift_en = 1'b0;
        tick();

        // ---------------- throttled shift 81 ----------------
        pat        = 8'h81;
        din        = pat;
        load_valid = 1'b1;
        tick();
        load_valid = 1'b0;
        for (int c = 0; c < 24; c++) begin
            shift_en = (c % 3 == 2);
            #1;
            check("thr_so",    {7'd0, so},         {7'd0, pat[7 - c/3]});
            check("thr_ready", {7'd0, load_ready}, {7'd0, (c == 23)});
            check("thr_last",  {7'd0, last},       {7'd0, (c/3 == 7)});
            tick();
        end
        shift_en = 1'b0;
        check("thr_end_idle", {7'd0, so_valid}, 8'd0);
        tick();

        // ---------------- handshake stall F0 / 0F ----------------
        din        = 8'hF0;
        load_valid = 1'b1;
        shift_en   = 1'b1;
        tick();
        din = 8'h0F;
        for (int i = 0; i < 8; i++) begin
            check("hs_ready", {7'd0, load_ready}, {7'd0, (i == 7)});
            check("hs_so",    {7'd0, so},         {7'd0, (i < 4)});
            tick();
        end
        load_valid = 1'b0;
        check("hs_new_msb",   {7'd0, so},       8'd0);
        check("hs_new_valid", {7'd0, so_valid}, 8'd1);
        check("hs_new_last",  {7'd0, last},     8'd0);
        repeat (8) tick();
        shift_en = 1'b0;
        check("hs_end_idle", {7'd0, so_valid}, 8'd0);
        tick();

        // ---------------- reset mid-frame ----------------
        din        = 8'hFF;
        load_valid = 1'b1;
        shift_en   = 1'b1;
        tick();
        load_valid = 1'b0;
        repeat (3) tick();
        check("mid_pre_valid", {7'd0, so_valid}, 8'd1);
        #1 clear_n = 1'b0;
        #1;
        check("mid_async_so",    {7'd0, so},       8'd0);
        check("mid_async_valid", {7'd0, so_valid}, 8'd0);
        tick();
        #2 clear_n = 1'b1;
        repeat (3) begin
            tick();
            check("mid_stay_idle", {7'd0, so_valid}, 8'd0);
            check("mid_stay_so",   {7'd0, so},       8'd0);
        end
        shift_en = 1'b0;

        // ---------------- randomized traffic ----------------
        for (int c = 0; c < 3000; c++) begin
            load_valid = ($urandom_range(0, 3) != 0);
            shift_en   = ($urandom_range(0, 3) != 0);
            din        = 8'($urandom);
            if ($urandom_range(0, 499) == 0) begin
                #1 clear_n = 1'b0;
                #2 clear_n = 1'b1;
            end
            tick();
        end
        load_valid = 1'b0;
        shift_en   = 1'b0;
        repeat (2) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
`default_nettype wire
